// File: rtl/iob_pwq_pkg.sv
// iob_pkg -- shared types for the IOB posted-write queue.
//   iob_state_t : master-side FSM states (IDLE, REQ, ACT, CMPL)
//   pwq_entry_t : one queued posted write {A, D, BE}
//   pwqMerge()  : byte-lane merge of a new write into an existing entry
// The entry field widths are fixed here (A[23:1], 16-bit data), so iob_pwq
// and pwq_ring must keep AW/DW at these values.
package iob_pkg;

    localparam int PWQ_AW = 23;
    localparam int PWQ_DW = 16;

    typedef logic [PWQ_AW-1:0] pwq_addr_t;
    typedef logic [PWQ_DW-1:0] pwq_data_t;

    typedef enum logic [1:0] {IDLE, REQ, ACT, CMPL} iob_state_t;

    typedef struct packed {
        pwq_addr_t  A;
        pwq_data_t  D;
        logic [1:0] BE;
    } pwq_entry_t;

    // Lanes enabled in upd overwrite cur; the resulting BE covers both writes.
    function automatic pwq_entry_t pwqMerge(input pwq_entry_t cur, input pwq_entry_t upd);
        pwq_entry_t res;
        res = cur;
        if (upd.BE[0]) res.D[7:0]        = upd.D[7:0];
        if (upd.BE[1]) res.D[PWQ_DW-1:8] = upd.D[PWQ_DW-1:8];
        res.BE = cur.BE | upd.BE;
        return res;
    endfunction

endpackage

// File: rtl/iob_pwq_ring.sv
// pwq_ring -- DEPTH-entry circular buffer holding posted writes.
// Ports:
//   clk, rstN            clock, asynchronous active-low reset
//   push, pushEntry      append an entry at the tail
//   pop                  drop the head entry
//   merge                fold pushEntry into the newest (tail) entry instead of appending
//   headEntry, tailEntry oldest / newest stored entry
//   empty                no entries stored
//   notFull              registered "room available" flag (drives PW_READY)
//   count                occupancy
module pwq_ring
    import iob_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       merge,
    input  pwq_entry_t                 pushEntry,
    output pwq_entry_t                 headEntry,
    output pwq_entry_t                 tailEntry,
    output logic                       empty,
    output logic                       notFull,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    pwq_entry_t    mem [DEPTH];
    logic [PW-1:0] headPtr;
    logic [PW-1:0] tailPtr;
    logic [PW-1:0] lastPtr;
    logic [CW-1:0] countNext;

    // DEPTH is a power of two, so pointer arithmetic wraps on its own.
    assign lastPtr   = tailPtr - PW'(1);
    assign headEntry = mem[headPtr];
    assign tailEntry = mem[lastPtr];
    assign empty     = (count == '0);

    always_comb begin
        countNext = count;
        if (push && !pop)      countNext = count + CW'(1);
        else if (pop && !push) countNext = count - CW'(1);
    end

    // notFull is computed from the next occupancy, so a slot freed by a pop
    // only becomes visible to the producer one cycle later.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
            notFull <= 1'b0;
        end else begin
            if (push) tailPtr <= tailPtr + PW'(1);
            if (pop)  headPtr <= headPtr + PW'(1);
            count   <= countNext;
            notFull <= (countNext != CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push)       mem[tailPtr] <= pushEntry;
        else if (merge) mem[lastPtr] <= pwqMerge(mem[lastPtr], pushEntry);
    end

endmodule

// File: rtl/iob_pwq.sv
// iob_pwq -- posted-write queue in front of the IOB bus master.
// Posted writes are queued and drained in order; a non-posted request
// (read or write) is only issued once the queue is empty.
// Ports:
//   CLK, nRES                       clock, asynchronous active-low reset
//   PW_VALID/PW_READY, PW_A/D/BE    posted-write push
//   NP_VALID, NP_RW, NP_A/BE/D      non-posted request; NP_DONE/NP_BERR completion
//   IOREQ, IORW, IOA, IOD, IOLDS, IOUDS   request to the IOB master
//   IOACT, IODONE, IOBERR           master handshake (already in CLK domain)
//   COUNT, ERR, ERR_CLR             occupancy, sticky posted-write error, clear
// Build option: define IOB_PWQ_MERGE_EN to merge a push into the tail entry
// when the addresses match and the tail is not being issued.
module iob_pwq
    import iob_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 23,
    parameter int DW    = 16
) (
    input  logic                       CLK,
    input  logic                       nRES,
    input  logic                       PW_VALID,
    output logic                       PW_READY,
    input  logic [AW-1:0]              PW_A,
    input  logic [DW-1:0]              PW_D,
    input  logic [1:0]                 PW_BE,
    input  logic                       NP_VALID,
    input  logic                       NP_RW,
    input  logic [AW-1:0]              NP_A,
    input  logic [1:0]                 NP_BE,
    input  logic [DW-1:0]              NP_D,
    output logic                       NP_DONE,
    output logic                       NP_BERR,
    output logic                       IOREQ,
    output logic                       IORW,
    output logic [AW-1:0]              IOA,
    output logic [DW-1:0]              IOD,
    output logic                       IOLDS,
    output logic                       IOUDS,
    input  logic                       IOACT,
    input  logic                       IODONE,
    input  logic                       IOBERR,
    output logic [$clog2(DEPTH+1)-1:0] COUNT,
    output logic                       ERR,
    input  logic                       ERR_CLR
);

    localparam int CW = $clog2(DEPTH+1);

    iob_state_t state;
    pwq_entry_t pushEntry;
    pwq_entry_t headEntry;
    pwq_entry_t tailEntry;
    logic       empty;
    logic       npSel;
    logic       berrLat;
    logic       bypassPop;
    logic       pop;
    logic       push;
    logic       mergeHit;
    logic       tailLocked;
    logic       errSet;

    assign pushEntry = '{A: pwq_addr_t'(PW_A), D: pwq_data_t'(PW_D), BE: PW_BE};

    // An entry with no byte enables has nothing to write: drop it from IDLE.
    assign bypassPop = (state == IDLE) && !empty && (headEntry.BE == 2'b00);
    assign pop       = bypassPop || ((state == CMPL) && !npSel);

    // With one entry left, the tail is the head; it must not change while
    // it is on the bus or being dropped.
    assign tailLocked = (COUNT == CW'(1)) && (bypassPop || ((state != IDLE) && !npSel));

`ifdef IOB_PWQ_MERGE_EN
    assign mergeHit = PW_VALID && !empty && !tailLocked && (tailEntry.A == pwq_addr_t'(PW_A));
`else
    logic unusedTail;
    logic unusedLock;
    assign unusedTail = ^tailEntry;
    assign unusedLock = tailLocked;
    assign mergeHit   = 1'b0;
`endif

    assign push   = PW_VALID && PW_READY && !mergeHit;
    assign errSet = (state == CMPL) && !npSel && berrLat;

    pwq_ring #(.DEPTH(DEPTH)) uRing (
        .clk       (CLK),
        .rstN      (nRES),
        .push      (push),
        .pop       (pop),
        .merge     (mergeHit),
        .pushEntry (pushEntry),
        .headEntry (headEntry),
        .tailEntry (tailEntry),
        .empty     (empty),
        .notFull   (PW_READY),
        .count     (COUNT)
    );

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            state   <= IDLE;
            npSel   <= 1'b0;
            berrLat <= 1'b0;
            IOREQ   <= 1'b0;
            IORW    <= 1'b1;
            IOA     <= '0;
            IOD     <= '0;
            IOLDS   <= 1'b0;
            IOUDS   <= 1'b0;
            NP_DONE <= 1'b0;
            NP_BERR <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            NP_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    // Posted writes always win; NP waits for an empty queue.
                    if (!empty) begin
                        if (headEntry.BE != 2'b00) begin
                            IOREQ <= 1'b1;
                            IORW  <= 1'b0;
                            IOA   <= AW'(headEntry.A);
                            IOD   <= DW'(headEntry.D);
                            IOLDS <= headEntry.BE[0];
                            IOUDS <= headEntry.BE[1];
                            npSel <= 1'b0;
                            state <= REQ;
                        end
                    end else if (NP_VALID) begin
                        IOREQ <= 1'b1;
                        IORW  <= NP_RW;
                        IOA   <= NP_A;
                        IOD   <= NP_D;
                        IOLDS <= NP_BE[0];
                        IOUDS <= NP_BE[1];
                        npSel <= 1'b1;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (IOACT) begin
                        IOREQ <= 1'b0;
                        state <= ACT;
                    end
                end
                ACT: begin
                    if (IODONE) begin
                        berrLat <= IOBERR;
                        if (npSel) begin
                            NP_DONE <= 1'b1;
                            NP_BERR <= IOBERR;
                        end
                        state <= CMPL;
                    end
                end
                default: state <= IDLE;
            endcase
            // A new error outranks a simultaneous clear.
            ERR <= errSet || (ERR && !ERR_CLR);
        end
    end

endmodule

// File: doc/iob_pwq.md
IOB_PWQ -- requirements
Module: iob_pwq

Interface
REQ-001 Parameter DEPTH, default 4: posted-write entries; power of two, 2..16.
REQ-002 Parameter AW, default 23: FSB word-address width (A[23:1]).
REQ-003 Parameter DW, default 16: data width.
REQ-004 CLK  in  1  FSB clock; every port is synchronous to its rising edge.
REQ-005 nRES  in  1  asynchronous active-low reset.
REQ-006 PW_VALID / PW_READY  in/out  1/1  posted-write push handshake.
REQ-007 PW_A, PW_D, PW_BE  in  AW/DW/2  push address, data, byte enables (BE[1]=upper, BE[0]=lower).
REQ-008 NP_VALID, NP_RW, NP_A, NP_BE  in  1/1/AW/2  non-posted request (read, or write when NP_RW=0).
REQ-009 NP_D  in  DW  non-posted write data.
REQ-010 NP_DONE, NP_BERR  out  1/1  one-cycle completion pulse and its bus-error flag.
REQ-011 IOREQ, IORW, IOA, IOD, IOLDS, IOUDS  out  1/1/AW/DW/1/1  request to the IOB master.
REQ-012 IOACT, IODONE, IOBERR  in  1/1/1  master handshake, already synchronised to CLK.
REQ-013 COUNT  out  $clog2(DEPTH+1)  occupancy; ERR  out  1  sticky posted-write bus error; ERR_CLR  in  1  clears ERR.

Function
REQ-014 Queue is FIFO-ordered; PW_READY = !full, registered; a push with PW_VALID&&PW_READY is stored in the same cycle.
REQ-015 When full, PW_READY stays 0 in the cycle of a pop; the freed slot is visible from the next cycle.
REQ-016 A push and a pop in the same cycle leave COUNT unchanged; pointers wrap modulo DEPTH.
REQ-017 FSM states are IDLE, REQ, ACT, CMPL.
REQ-018 IDLE->REQ on non-empty queue (head entry issued), or on NP_VALID with an empty queue.
REQ-019 A pending NP request waits until the queue is empty: posted writes always drain first.
REQ-020 In REQ, IOREQ=1 with IOA/IOD/IORW/IOLDS/IOUDS driven from the selected source; REQ->ACT on IOACT=1.
REQ-021 In ACT, IOREQ=0; ACT->CMPL on IODONE=1.
REQ-022 In CMPL, a posted entry is popped (COUNT decrements); an NP cycle pulses NP_DONE=1 for one cycle with NP_BERR=IOBERR sampled at IODONE. CMPL->IDLE.
REQ-023 IOBERR on a posted write sets ERR; the entry is still popped; draining continues.
REQ-024 ERR_CLR clears ERR; if a set and a clear occur in the same cycle, the set wins.
REQ-025 IOLDS/IOUDS are active-high copies of BE[0]/BE[1]; an entry with BE=00 is accepted but never issued (popped in 1 cycle).
REQ-026 Outputs hold stable from REQ entry until CMPL; the head entry is not modifiable while issued.

Reset
REQ-027 nRES low: the queue is emptied and the FSM goes to IDLE.
REQ-028 During nRES low: IOREQ=0, IORW=1, IOLDS=IOUDS=0, IOA=0, IOD=0, PW_READY=0, NP_DONE=0, NP_BERR=0, ERR=0, COUNT=0.
REQ-029 Reset mid-operation drops IOREQ immediately and discards all entries; no NP_DONE is emitted.
REQ-030 PW_READY rises the first cycle after nRES deasserts.

Configuration
REQ-031 Macro IOB_PWQ_MERGE_EN, when defined: a push whose PW_A equals the tail entry's address, tail not issued, merges into the tail.
REQ-032 Merge rule: per byte lane, PW_BE lanes overwrite data; BE becomes the OR of old and new; COUNT is unchanged; accepted even when full.
REQ-033 Without IOB_PWQ_MERGE_EN: every push allocates a new entry and no comparator is built.

Structure
REQ-034 Package iob_pkg holds the FSM state enum (IDLE, REQ, ACT, CMPL) and the pwq_entry_t struct {A, D, BE}.
REQ-035 One sub-module pwq_ring: DEPTH-entry register array with head/tail pointers, full/empty, COUNT and the merge port; iob_pwq holds the FSM and muxing.

Verification
REQ-036 Push 4 writes (A=0x0F0001..4) at DEPTH=4 -> PW_READY=0 after the 4th; issued in order; COUNT 4->0.
REQ-037 Queue holds 2 writes, then NP read at A=0x0C0000 -> read IOREQ only after 2nd write CMPL; one NP_DONE pulse.
REQ-038 IOBERR=1 on the 1st of 2 posted writes -> ERR=1, 2nd still issued; ERR_CLR then ERR=0.
REQ-039 nRES low while in ACT with COUNT=3 -> IOREQ=0, COUNT=0, no NP_DONE; PW_READY=1 one cycle after release.
REQ-040 MERGE_EN: push A=0x0E0000 BE=01 D=0x0011, then same A BE=10 D=0x2200 before issue -> one entry, BE=11, D=0x2211.
REQ-041 Full queue, pop and PW_VALID in same cycle -> push refused that cycle, accepted next; COUNT 4->3->4.
